sprite_fetch_scheduler: RTL and testbench
=========================================

Name: sprite_fetch_scheduler

Overview:
- Time-shares one single-port, read-only sprite/palette-index memory among three requesters: character1, character2 and background.
- Per pixel slot, it fetches the 8-bit palette index for each active layer and registers them with their layer flags.
- It presents index plus flag as one coherent set to the colour-mapping stage.
- It sits between the VGA timing and sprite address generators upstream and the colour mapper downstream.

Parameters:
ADDR_W, 18, sprite memory address width
ROM_LAT, 1, memory read latency in Clk cycles (1..3)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
pixel_tick  in  1  one-cycle pulse that starts a pixel slot
is_character1  in  1  pixel lies inside character1 sprite box
is_character2  in  1  pixel lies inside character2 sprite box
is_background  in  1  pixel lies inside background region
char1_addr  in  ADDR_W  character1 index address
char2_addr  in  ADDR_W  character2 index address
bg_addr  in  ADDR_W  background index address
rom_rd  out  1  memory read strobe
rom_addr  out  ADDR_W  memory address, valid while rom_rd=1
rom_q  in  8  memory read data, valid ROM_LAT cycles after rom_rd
character1_data  out  8  registered character1 palette index
character2_data  out  8  registered character2 palette index
background_data  out  8  registered background palette index
is_character1_q  out  1  registered layer flag for character1
is_character2_q  out  1  registered layer flag for character2
is_background_q  out  1  registered layer flag for background
out_valid  out  1  one-cycle pulse when the output set updates
overrun  out  1  sticky: pixel_tick arrived while busy
overrun_clr  in  1  clears overrun

Behaviour:
- Reset (async, Reset=0): all outputs 0, state IDLE, tag pipeline empty, snapshot registers 0. Memory data arriving after reset is discarded because its tag was cleared.
- States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE, pixel_tick=1 (cycle 0): snapshot the three flags and three addresses. Go to ISSUE if any flag is set, otherwise to DONE.
- ISSUE: one read per cycle, fixed order C1, C2, BG, inactive layers skipped.
  - rom_rd=1 and rom_addr=snapshot address are combinational from state and issue pointer.
  - n active layers give issue cycles 1..n.
  - Each issue pushes {valid, id} into a ROM_LAT-deep tag pipeline.
  - After the last issue go to DRAIN.
- DRAIN: when the head tag is valid, capture rom_q into that layer's holding register. Go to DONE in the cycle after the last capture (the tag pipeline is empty).
- DONE (one cycle):
  - Copy the holding registers and snapshot flags to the outputs.
  - Inactive layers output index 0 (transparent).
  - out_valid=1 in the following cycle, concurrent with the new output values.
  - Return to IDLE.
- Latency:
  - n>=1: outputs and out_valid visible in cycle n+ROM_LAT+2.
  - n=0: cycle 2.
  - Worst case (n=3, ROM_LAT=1): 6 cycles.
- rom_rd is never asserted outside ISSUE. The rom_addr value is don't-care when rom_rd=0 but is driven to 0.
- pixel_tick while not IDLE:
  - Ignored; the slot in progress completes unchanged.
  - overrun is set.
  - Outputs keep their previous set until the next DONE.
- overrun_clr and an overrun event in the same cycle: set wins.
- Outputs hold between out_valid pulses. The mapper may sample at any time and always sees a coherent set.
- Holding registers are cleared at each IDLE->ISSUE transition so stale indices never leak.
- Width rules: indices pass unmodified; no arithmetic on addresses.

Decomposition:
- sprite_pkg:
  - ADDR_W default
  - layer id enum (LAYER_C1=0, LAYER_C2=1, LAYER_BG=2)
  - state enum (IDLE, ISSUE, DRAIN, DONE)
  - index width constant IDX_W=8 and TRANSPARENT_IDX=0
- Sub-module rom_return_tracker: ROM_LAT-deep {valid, id} shift register with push/head/empty outputs.

Test Plan:
- Reset: Reset=0 mid-ISSUE with ROM_LAT=2 -> all outputs 0 immediately. After release, the late rom_q is not captured and out_valid stays 0 until the next tick.
- All three layers, ROM_LAT=1, memory model rom_q=addr[7:0], addresses 0x105/0x2A7/0x033:
  - rom_rd in cycles 1-3 with addresses in order C1, C2, BG.
  - Cycle 6: outputs 0x05/0xA7/0x33, all flags 1, out_valid=1 for one cycle.
- Only background, addr 0x0FF -> one read in cycle 1. Cycle 4: background_data=0xFF, other indices 0, other flags 0.
- No layer active -> no rom_rd. Cycle 2: all outputs 0 and out_valid=1.
- Overrun: second pixel_tick in cycle 2 of a 3-layer slot -> overrun=1, first slot still completes in cycle 6, no second slot. overrun_clr for one cycle -> overrun=0.
- ROM_LAT=3, C1 and C2 active (0x011, 0x022) -> reads in cycles 1-2, out_valid in cycle 7 with data 0x11/0x22.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite fetch scheduler.
// Layer ids double as bit positions in every per-layer flag mask.
package sprite_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 18;
  localparam int unsigned IDX_W          = 8;
  localparam int unsigned NUM_LAYERS     = 3;
  localparam logic [IDX_W-1:0] TRANSPARENT_IDX = '0;

  typedef enum logic [1:0] {
    LAYER_C1 = 2'd0,
    LAYER_C2 = 2'd1,
    LAYER_BG = 2'd2
  } layer_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [NUM_LAYERS-1:0] layer_mask_t;

  typedef struct packed {
    logic   vld;
    layer_e id;
  } rom_tag_t;

  // Lowest-numbered active layer; fixed C1, C2, BG priority.
  function automatic layer_e first_layer(input layer_mask_t mask);
    if (mask[0]) return LAYER_C1;
    if (mask[1]) return LAYER_C2;
    return LAYER_BG;
  endfunction

endpackage

// File: rtl/rom_return_tracker.sv
// Tag shift register matching the memory read latency; the head tag
// names the layer that owns the rom_q word arriving this cycle.
module rom_return_tracker
  import sprite_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic     Clk,
  input  logic     Reset,
  input  logic     push,
  input  layer_e   push_id,
  output rom_tag_t head,
  output logic     rest_empty_c
);

  rom_tag_t pipe_q [DEPTH];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= push ? '{vld: 1'b1, id: push_id} : '0;
      for (int i = 1; i < int'(DEPTH); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign head = pipe_q[DEPTH-1];

  // True when nothing except the head is in flight.
  always_comb begin
    rest_empty_c = 1'b1;
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      if (pipe_q[i].vld) rest_empty_c = 1'b0;
    end
  end

endmodule

// File: rtl/sprite_fetch_scheduler.sv
// Time-shares one read-only index memory among character1, character2 and
// background, publishing each pixel slot's indices and flags as one set.
module sprite_fetch_scheduler
  import sprite_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pixel_tick,
  input  logic              is_character1,
  input  logic              is_character2,
  input  logic              is_background,
  input  logic [ADDR_W-1:0] char1_addr,
  input  logic [ADDR_W-1:0] char2_addr,
  input  logic [ADDR_W-1:0] bg_addr,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  character1_data,
  output logic [IDX_W-1:0]  character2_data,
  output logic [IDX_W-1:0]  background_data,
  output logic              is_character1_q,
  output logic              is_character2_q,
  output logic              is_background_q,
  output logic              out_valid,
  output logic              overrun,
  input  logic              overrun_clr
);

  state_e            state_q, state_d;
  layer_mask_t       flags_q, pend_q, flags_out_q;
  layer_mask_t       flags_in_c, pend_rest_c;
  logic [ADDR_W-1:0] addr_q [NUM_LAYERS];
  logic [IDX_W-1:0]  hold_q [NUM_LAYERS];
  logic [IDX_W-1:0]  data_q [NUM_LAYERS];
  logic              out_valid_q, overrun_q;
  layer_e            issue_id_c;
  logic              push_c, rest_empty_c;
  rom_tag_t          head;

  assign flags_in_c  = {is_background, is_character2, is_character1};
  assign issue_id_c  = first_layer(pend_q);
  assign pend_rest_c = pend_q & ~(layer_mask_t'(1) << issue_id_c);

  rom_return_tracker #(.DEPTH(ROM_LAT)) u_tracker (
    .Clk          (Clk),
    .Reset        (Reset),
    .push         (push_c),
    .push_id      (issue_id_c),
    .head         (head),
    .rest_empty_c (rest_empty_c)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (pixel_tick) state_d = (|flags_in_c) ? ISSUE : DONE;
      ISSUE: if (pend_rest_c == '0) state_d = DRAIN;
      DRAIN: if (rest_empty_c) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory strobe and address come straight from state and issue pointer.
  always_comb begin
    rom_rd   = 1'b0;
    rom_addr = '0;
    push_c   = 1'b0;
    if (state_q == ISSUE) begin
      rom_rd   = 1'b1;
      rom_addr = addr_q[issue_id_c];
      push_c   = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      flags_q     <= '0;
      pend_q      <= '0;
      flags_out_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < int'(NUM_LAYERS); i++) begin
        addr_q[i] <= '0;
        hold_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (state_q == IDLE && pixel_tick) begin
        flags_q   <= flags_in_c;
        pend_q    <= flags_in_c;
        addr_q[0] <= char1_addr;
        addr_q[1] <= char2_addr;
        addr_q[2] <= bg_addr;
        if (|flags_in_c) begin
          for (int i = 0; i < int'(NUM_LAYERS); i++) hold_q[i] <= '0;
        end
      end
      if (state_q == ISSUE) pend_q <= pend_rest_c;
      if (head.vld) hold_q[head.id] <= rom_q;
      // Publish the whole set at once; inactive layers read as transparent.
      if (state_q == DONE) begin
        flags_out_q <= flags_q;
        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
          data_q[i] <= flags_q[i] ? hold_q[i] : TRANSPARENT_IDX;
        end
      end
      out_valid_q <= (state_q == DONE);
      if (pixel_tick && state_q != IDLE) overrun_q <= 1'b1;
      else if (overrun_clr)              overrun_q <= 1'b0;
    end
  end

  assign character1_data = data_q[0];
  assign character2_data = data_q[1];
  assign background_data = data_q[2];
  assign is_character1_q = flags_out_q[0];
  assign is_character2_q = flags_out_q[1];
  assign is_background_q = flags_out_q[2];
  assign out_valid       = out_valid_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// Directed bench: three schedulers (ROM_LAT 1, 2, 3) share stimulus, each
// with its own latency-matched memory returning addr[7:0].
module tb_sprite_fetch_scheduler;

  localparam int unsigned AW = 18;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          pixel_tick, overrun_clr;
  logic          is_c1, is_c2, is_bg;
  logic [AW-1:0] a1, a2, ab;

  logic          rom_rd   [3];
  logic [AW-1:0] rom_addr [3];
  logic [7:0]    rom_q    [3];
  logic [7:0]    c1_d [3], c2_d [3], bg_d [3];
  logic          c1_f [3], c2_f [3], bg_f [3];
  logic          ov [3], ovr [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = g + 1;
    logic [7:0] mem_pipe [LAT];

    sprite_fetch_scheduler #(.ADDR_W(AW), .ROM_LAT(LAT)) dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .pixel_tick      (pixel_tick),
      .is_character1   (is_c1),
      .is_character2   (is_c2),
      .is_background   (is_bg),
      .char1_addr      (a1),
      .char2_addr      (a2),
      .bg_addr         (ab),
      .rom_rd          (rom_rd[g]),
      .rom_addr        (rom_addr[g]),
      .rom_q           (rom_q[g]),
      .character1_data (c1_d[g]),
      .character2_data (c2_d[g]),
      .background_data (bg_d[g]),
      .is_character1_q (c1_f[g]),
      .is_character2_q (c2_f[g]),
      .is_background_q (bg_f[g]),
      .out_valid       (ov[g]),
      .overrun         (ovr[g]),
      .overrun_clr     (overrun_clr)
    );

    // Memory keeps running through DUT reset; junk 0xEE when not read.
    always @(posedge Clk) begin
      mem_pipe[0] <= rom_rd[g] ? rom_addr[g][7:0] : 8'hEE;
      for (int i = 1; i < int'(LAT); i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign rom_q[g] = mem_pipe[LAT-1];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic check_rd(input string tag, input int k, input logic rd, input logic [AW-1:0] addr);
    check_eq({tag, " rom_rd"}, 32'(rom_rd[k]), 32'(rd));
    check_eq({tag, " rom_addr"}, 32'(rom_addr[k]), 32'(addr));
  endtask

  task automatic check_set(input string tag, input int k, input logic [7:0] e1, input logic [7:0] e2,
                           input logic [7:0] eb, input logic [2:0] ef, input logic ev);
    check_eq({tag, " c1_data"}, 32'(c1_d[k]), 32'(e1));
    check_eq({tag, " c2_data"}, 32'(c2_d[k]), 32'(e2));
    check_eq({tag, " bg_data"}, 32'(bg_d[k]), 32'(eb));
    check_eq({tag, " flags"}, 32'({bg_f[k], c2_f[k], c1_f[k]}), 32'(ef));
    check_eq({tag, " out_valid"}, 32'(ov[k]), 32'(ev));
  endtask

  // Present a slot request in the current cycle (cycle 0); returns in cycle 1.
  task automatic start_slot(input logic [2:0] fl, input logic [AW-1:0] x1,
                            input logic [AW-1:0] x2, input logic [AW-1:0] xb);
    {is_bg, is_c2, is_c1} = fl;
    a1 = x1;
    a2 = x2;
    ab = xb;
    pixel_tick = 1'b1;
    step();
    pixel_tick = 1'b0;
  endtask

  initial begin
    Reset = 1'b0;
    pixel_tick = 1'b0;
    overrun_clr = 1'b0;
    {is_bg, is_c2, is_c1} = 3'b000;
    a1 = '0;
    a2 = '0;
    ab = '0;
    step(2);
    check_set("reset", 0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
    check_rd("reset", 0, 1'b0, '0);
    check_eq("reset overrun", 32'(ovr[0]), 32'd0);
    Reset = 1'b1;
    step(2);

    // All three layers, ROM_LAT=1
    start_slot(3'b111, 18'h105, 18'h2A7, 18'h033);
    check_rd("all c1", 0, 1'b1, 18'h105);
    step();
    check_rd("all c2", 0, 1'b1, 18'h2A7);
    step();
    check_rd("all c3", 0, 1'b1, 18'h033);
    step();
    check_rd("all c4", 0, 1'b0, '0);
    step();
    check_eq("all c5 out_valid", 32'(ov[0]), 32'd0);
    step();
    check_set("all c6", 0, 8'h05, 8'hA7, 8'h33, 3'b111, 1'b1);
    step();
    check_set("all c7", 0, 8'h05, 8'hA7, 8'h33, 3'b111, 1'b0);
    step(10);

    // Background only, ROM_LAT=1
    start_slot(3'b100, 18'h3C1, 18'h3C2, 18'h0FF);
    check_rd("bg c1", 0, 1'b1, 18'h0FF);
    step();
    check_rd("bg c2", 0, 1'b0, '0);
    step();
    check_set("bg c3 hold", 0, 8'h05, 8'hA7, 8'h33, 3'b111, 1'b0);
    step();
    check_set("bg c4", 0, 8'h00, 8'h00, 8'hFF, 3'b100, 1'b1);
    step(10);

    // No active layer
    start_slot(3'b000, 18'h011, 18'h022, 18'h033);
    check_rd("none c1", 0, 1'b0, '0);
    step();
    check_set("none c2", 0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1);
    step(10);

    // Overrun: second tick during a 3-layer slot
    start_slot(3'b111, 18'h1AB, 18'h0CD, 18'h3EF);
    step();
    check_eq("ovr before", 32'(ovr[0]), 32'd0);
    pixel_tick = 1'b1;
    a1 = 18'h001;
    step();
    pixel_tick = 1'b0;
    check_eq("ovr set", 32'(ovr[0]), 32'd1);
    step(3);
    check_set("ovr c6", 0, 8'hAB, 8'hCD, 8'hEF, 3'b111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("ovr no 2nd rd", 32'(rom_rd[0]), 32'd0);
      check_eq("ovr no 2nd valid", 32'(ov[0]), 32'd0);
    end
    check_eq("ovr sticky", 32'(ovr[0]), 32'd1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check_eq("ovr cleared", 32'(ovr[0]), 32'd0);
    step(4);

    // ROM_LAT=3, C1 and C2 active
    start_slot(3'b011, 18'h011, 18'h022, 18'h3FF);
    check_rd("lat3 c1", 2, 1'b1, 18'h011);
    step();
    check_rd("lat3 c2", 2, 1'b1, 18'h022);
    step();
    check_rd("lat3 c3", 2, 1'b0, '0);
    step(3);
    check_eq("lat3 c6 out_valid", 32'(ov[2]), 32'd0);
    step();
    check_set("lat3 c7", 2, 8'h11, 8'h22, 8'h00, 3'b011, 1'b1);
    step(10);

    // Reset mid-ISSUE with ROM_LAT=2; late rom_q must be dropped
    start_slot(3'b111, 18'h1C1, 18'h1C2, 18'h1C3);
    check_rd("rst c1", 1, 1'b1, 18'h1C1);
    step();
    Reset = 1'b0;
    #1;
    check_rd("rst async", 1, 1'b0, '0);
    check_set("rst async", 1, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
    check_eq("rst async overrun", 32'(ovr[1]), 32'd0);
    #2;
    Reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("rst no valid", 32'(ov[1]), 32'd0);
      check_eq("rst no rd", 32'(rom_rd[1]), 32'd0);
    end
    check_set("rst held", 1, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
    start_slot(3'b001, 18'h055, 18'h066, 18'h077);
    step(3);
    check_eq("rst next c4", 32'(ov[1]), 32'd0);
    step();
    check_set("rst next c5", 1, 8'h55, 8'h00, 8'h00, 3'b001, 1'b1);
    step(10);

    // Overrun set beats a simultaneous clear
    start_slot(3'b001, 18'h077, 18'h000, 18'h000);
    pixel_tick = 1'b1;
    overrun_clr = 1'b1;
    step();
    pixel_tick = 1'b0;
    overrun_clr = 1'b0;
    check_eq("set wins", 32'(ovr[0]), 32'd1);
    step(2);
    check_set("set wins c4", 0, 8'h77, 8'h00, 8'h00, 3'b001, 1'b1);
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
